mix_sequencer: RTL
==================

Name: mix_sequencer

Overview:
- Time-multiplexed controller for the 8-voice audio mixer; replaces the parallel adder tree with one accumulator, sequenced once per sample frame.
- Each `sample_tick` starts one frame: the block walks channels 0..NUM_CH-1 via `chan_sel`, applies per-channel mute and attenuation, sums, then limits to 16 bits.
- The mixed sample goes to the codec interface over a valid/ready handshake.
- Sits between the voice sources (muxed by `chan_sel`) and the audio codec serializer.

Parameters:
- NUM_CH, 8, number of voices; power of two, 2..16.
- DW, 16, sample width; signed two's complement.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle frame strobe (e.g. 48 kHz).
- chan_sel  out  log2(NUM_CH)  channel select to the voice mux.
- chan_data  in  DW  selected voice sample, valid the cycle after `chan_sel`.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  log2(NUM_CH)  channel being configured.
- cfg_data  in  4  [3]=mute, [2:0]=attenuation shift.
- out_data  out  DW  mixed sample.
- out_valid  out  1  `out_data` valid.
- out_ready  in  1  consumer accepts when `out_valid` && `out_ready`.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky: a tick was dropped.
- overrun_clr  in  1  clears `overrun`.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, chan_sel=0, out_data=0, out_valid=0, busy=0, overrun=0.
  - Accumulator=0; all config registers=0 (unmuted, shift 0).
- Config:
  - `cfg_we` writes `cfg_data` to `cfg[cfg_addr]` in any state.
  - On an accepted tick, all cfg registers are copied to a frame snapshot; the frame uses only the snapshot.
  - A write on the same cycle as an accepted tick is NOT in that frame's snapshot.
- States: IDLE -> RUN -> DRAIN -> OUT -> IDLE.
  - IDLE: `sample_tick` -> RUN; clear accumulator; take snapshot; `chan_sel`=0.
  - RUN: `chan_sel` increments 0..NUM_CH-1, one per cycle; after `chan_sel`=NUM_CH-1 -> DRAIN.
  - Pipeline: `chan_data` for sel k is accumulated on the cycle after sel k is presented.
  - DRAIN: accumulate the last channel; register the limited result into `out_data`; -> OUT.
  - OUT: `out_valid`=1, `out_data` held stable; on `out_ready` -> IDLE, `out_valid`=0 on the next cycle.
- Latency: tick at cycle T -> `out_valid` first high at T+NUM_CH+2 (T+10 for 8 channels).
- Frame rate: minimum frame = NUM_CH+3 cycles if `out_ready` is tied high.
- Gain stage per channel:
  - Muted -> contributes 0.
  - Else contributes `chan_data >>> shift` (arithmetic, sign preserved).
- Arithmetic:
  - Accumulator is signed, width DW+log2(NUM_CH) (19 bits at defaults).
  - Operands are sign-extended; no overflow is possible inside the accumulator.
- Overrun: `sample_tick` in RUN, DRAIN or OUT is ignored and sets `overrun`.
  - `overrun_clr` clears it.
  - If a tick and `overrun_clr` occur on the same cycle, set wins.
- `chan_sel` holds 0 in IDLE.
- Reset mid-frame aborts the frame; no partial `out_valid` is produced.

Optional Feature:
- Macro MIXSEQ_SATURATE_EN.
- Defined: `out_data` = accumulator clamped to [-2^(DW-1), 2^(DW-1)-1] (16'h8000..16'h7FFF).
- Undefined: `out_data` = accumulator >>> log2(NUM_CH) (average); cannot clip.
- Interface is identical in both builds.

Decomposition:
- Package `mix_pkg`:
  - NUM_CH/DW defaults.
  - Derived `SEL_W` and `ACC_W` localparams.
  - Cfg field bit positions (`MUTE_BIT`, `SHIFT_MSB/LSB`).
  - State enum/encoding (IDLE, RUN, DRAIN, OUT).
- One natural sub-module: `mix_gain_stage`, combinational mute + arithmetic shift + sign-extend to `ACC_W`.
- FSM, counter, accumulator and limiter stay in `mix_sequencer`.

Test Plan:
- Reset release, all voices = 1000, cfg default, tick, `out_ready`=1 -> `out_valid` at T+10, `out_data`=8000 (saturate build) / 1000 (average build); `chan_sel` sequence 0..7 observed.
- Voice 0 = -4000, cfg ch0 shift=2, others muted, tick -> saturate build `out_data`=-1000 (16'hFC18).
- All voices 16'h7FFF, tick -> saturate build `out_data`=16'h7FFF; average build 16'h7FFF. All 16'h8000 -> 16'h8000 in both.
- `out_ready`=0 held, second tick during OUT -> `overrun`=1, `out_data` unchanged, `out_valid` stays 1. Then `out_ready`=1 -> IDLE. `overrun_clr` -> `overrun`=0.
- Cfg write muting ch3 on the same cycle as the tick -> ch3 still summed this frame, muted the next frame.
- Assert reset at T+5 mid-frame -> all outputs 0 immediately. Deassert, tick -> a clean frame with the correct sum.

Source files
------------

// File: rtl/mix_pkg.sv
// -----------------------------------------------------------------------------
// mix_pkg
// Shared definitions for the time-multiplexed 8-voice mixer controller.
//   - Default voice count and sample width, plus derived select/accumulator
//     widths at those defaults.
//   - Bit positions of the per-channel config word {mute, shift[2:0]}.
//   - Sequencer state encoding.
// -----------------------------------------------------------------------------
package mix_pkg;

   localparam int NUM_CH_DEF = 8;
   localparam int DW_DEF     = 16;

   localparam int SEL_W = $clog2(NUM_CH_DEF);
   localparam int ACC_W = DW_DEF + SEL_W;

   // Per-channel config word layout.
   localparam int CFG_W     = 4;
   localparam int MUTE_BIT  = 3;
   localparam int SHIFT_MSB = 2;
   localparam int SHIFT_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/mix_gain_stage.sv
// -----------------------------------------------------------------------------
// mix_gain_stage
// Combinational per-voice gain: mute, arithmetic right shift (attenuation),
// then sign-extend to the accumulator width.
// Ports:
//   sample   in  DW        signed voice sample
//   cfg      in  CFG_W     {mute, shift[2:0]}
//   contrib  out ACC_BITS  signed contribution to the frame sum
// -----------------------------------------------------------------------------
module mix_gain_stage
   import mix_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int ACC_BITS = ACC_W
) (
   input  logic signed [DW-1:0]       sample,
   input  logic        [CFG_W-1:0]    cfg,
   output logic signed [ACC_BITS-1:0] contrib
);

   logic signed [DW-1:0] shifted;

   // Arithmetic shift keeps the sign, so -4000 >>> 2 gives -1000.
   assign shifted = sample >>> cfg[SHIFT_MSB:SHIFT_LSB];
   assign contrib = cfg[MUTE_BIT] ? '0 : ACC_BITS'(shifted);

endmodule

// File: rtl/mix_sequencer.sv
// -----------------------------------------------------------------------------
// mix_sequencer
// Time-multiplexed mixer controller. Each accepted sample_tick walks the voice
// mux through all channels, accumulates gained samples in one signed
// accumulator, limits the sum to DW bits and hands it to the codec over a
// valid/ready handshake.
// Build option: define MIXSEQ_SATURATE_EN to clamp the sum to the DW range;
// otherwise the output is the channel average (sum >>> log2(NUM_CH)).
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   sample_tick  in   one-cycle frame strobe
//   chan_sel     out  voice mux select (data returns one cycle later)
//   chan_data    in   selected voice sample
//   cfg_we/addr/data in  per-channel config write {mute, shift[2:0]}
//   out_data     out  mixed sample, stable while out_valid
//   out_valid    out  out_data valid
//   out_ready    in   consumer accept
//   busy         out  frame in progress (state != IDLE)
//   overrun      out  sticky: a tick arrived while busy
//   overrun_clr  in   clears overrun (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module mix_sequencer
   import mix_pkg::*;
#(
   parameter  int NUM_CH   = NUM_CH_DEF,
   parameter  int DW       = DW_DEF,
   localparam int SEL_BITS = $clog2(NUM_CH),
   localparam int ACC_BITS = DW + SEL_BITS
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                sample_tick,
   output logic [SEL_BITS-1:0] chan_sel,
   input  logic [DW-1:0]       chan_data,
   input  logic                cfg_we,
   input  logic [SEL_BITS-1:0] cfg_addr,
   input  logic [CFG_W-1:0]    cfg_data,
   output logic [DW-1:0]       out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                overrun,
   input  logic                overrun_clr
);

   state_t state, state_nx;

   logic [CFG_W-1:0] cfg_q  [NUM_CH];
   logic [CFG_W-1:0] snap_q [NUM_CH];

   logic signed [ACC_BITS-1:0] acc, acc_sum, contrib;
   logic [SEL_BITS-1:0]        data_idx;
   logic                       take_tick, acc_en;
   logic [DW-1:0]              limited;

   assign take_tick = (state == IDLE) && sample_tick;

   // chan_data lags chan_sel by one cycle, so the sample on the bus belongs to
   // chan_sel-1. chan_sel wraps to 0 on entering DRAIN, which makes this
   // point at the last channel there as well.
   assign data_idx = chan_sel - SEL_BITS'(1);
   assign acc_en   = ((state == RUN) && (chan_sel != '0)) || (state == DRAIN);

   mix_gain_stage #(
      .DW       (DW),
      .ACC_BITS (ACC_BITS)
   ) u_gain (
      .sample  (chan_data),
      .cfg     (snap_q[data_idx]),
      .contrib (contrib)
   );

   assign acc_sum = acc + contrib;

`ifdef MIXSEQ_SATURATE_EN
   localparam logic signed [ACC_BITS-1:0] SAT_HI = {{(SEL_BITS+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_BITS-1:0] SAT_LO = {{(SEL_BITS+1){1'b1}}, {(DW-1){1'b0}}};

   assign limited = (acc_sum > SAT_HI) ? {1'b0, {(DW-1){1'b1}}} :
                    (acc_sum < SAT_LO) ? {1'b1, {(DW-1){1'b0}}} :
                                         acc_sum[DW-1:0];
`else
   // Dividing by the channel count brings any sum back into DW range.
   assign limited = DW'(acc_sum >>> SEL_BITS);
`endif

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (sample_tick) state_nx = RUN;
         RUN:     if (chan_sel == SEL_BITS'(NUM_CH - 1)) state_nx = DRAIN;
         DRAIN:   state_nx = OUT;
         OUT:     if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign out_valid = (state == OUT);

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         chan_sel <= '0;
         acc      <= '0;
         out_data <= '0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nx;
         chan_sel <= '0;
         case (state)
            IDLE:  if (sample_tick) acc <= '0;
            RUN: begin
               chan_sel <= chan_sel + SEL_BITS'(1);
               if (acc_en) acc <= acc_sum;
            end
            DRAIN: begin
               acc      <= acc_sum;
               out_data <= limited;
            end
            default: ;
         endcase
         if (sample_tick && (state != IDLE)) overrun <= 1'b1;
         else if (overrun_clr)               overrun <= 1'b0;
      end
   end

   // NOTE: these are small flop arrays, not RAM; they are reset because the
   // power-on default (unmuted, shift 0) is part of the block's behaviour.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cfg_q[i]  <= '0;
            snap_q[i] <= '0;
         end
      end else begin
         if (cfg_we)    cfg_q[cfg_addr] <= cfg_data;
         // Snapshot reads the pre-edge config, so a same-cycle write lands
         // in the next frame.
         if (take_tick) snap_q <= cfg_q;
      end
   end

endmodule
